// File: rtl/bcd_7segment_if.sv
// Digit/segment bundle for bcd_7segment.
// The master drives the digit code and control lines and the slave returns segment drive and
// error flag.
interface bcd_7segment_if;
  logic       en;
  logic [3:0] bcd;
  logic       bl;
  logic       lt;
  logic [6:0] seg;
  logic       err;

  modport master (
    output en,
    output bcd,
    output bl,
    output lt,
    input  seg,
    input  err
  );

  modport slave (
    input  en,
    input  bcd,
    input  bl,
    input  lt,
    output seg,
    output err
  );
endinterface

// File: rtl/bcd_7segment.sv
// Registered BCD-to-seven-segment decoder with blank, lamp test and invalid-code flag.
// The segment outputs are active-high, and the bit order is {g,f,e,d,c,b,a}.
// Define BCD7SEG_HEX_EN to show hex glyphs for codes 10-15 instead of blanking them and
// flagging them.
module bcd_7segment (
  input logic           clk,
  input logic           rst,
  bcd_7segment_if.slave bus
);

  logic [6:0] seg_q, seg_d;
  logic       err_q, err_d;
  logic [6:0] glyph;
  logic       glyph_bad;

  // Digit code to glyph; glyph_bad marks codes with no displayable glyph in this build
  always_comb begin
    glyph     = 7'b0000000;
    glyph_bad = 1'b0;
    case (bus.bcd)
      4'd0:  glyph = 7'b0111111;
      4'd1:  glyph = 7'b0000110;
      4'd2:  glyph = 7'b1011011;
      4'd3:  glyph = 7'b1001111;
      4'd4:  glyph = 7'b1100110;
      4'd5:  glyph = 7'b1101101;
      4'd6:  glyph = 7'b1111101;
      4'd7:  glyph = 7'b0000111;
      4'd8:  glyph = 7'b1111111;
      4'd9:  glyph = 7'b1101111;
`ifdef BCD7SEG_HEX_EN
      4'd10: glyph = 7'b1110111;
      4'd11: glyph = 7'b1111100;
      4'd12: glyph = 7'b0111001;
      4'd13: glyph = 7'b1011110;
      4'd14: glyph = 7'b1111001;
      4'd15: glyph = 7'b1110001;
`else
      default: begin
        glyph     = 7'b0000000;
        glyph_bad = 1'b1;
      end
`endif
    endcase
  end

  // Override priority: blank beats lamp test, and both beat the decode path.
  // The err flag only follows the decode path.
  always_comb begin
    seg_d = glyph;
    err_d = glyph_bad;
    if (bus.bl) begin
      seg_d = 7'b0000000;
      err_d = 1'b0;
    end else if (bus.lt) begin
      seg_d = 7'b1111111;
      err_d = 1'b0;
    end
  end

  // Output registers load only when enabled. Reset clears them without waiting for a clock.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg_q <= 7'b0000000;
      err_q <= 1'b0;
    end else if (bus.en) begin
      seg_q <= seg_d;
      err_q <= err_d;
    end
  end

  assign bus.seg = seg_q;
  assign bus.err = err_q;

endmodule

// File: tb/tb_bcd_7segment.sv
// Self-checking bench for bcd_7segment.
// A table-driven reference model predicts the registered outputs cycle by cycle.
module tb_bcd_7segment;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   passed = 0;

  logic [6:0] tbl [16];
  logic [6:0] m_seg;
  logic       m_err;

  bcd_7segment_if bus_if ();

  bcd_7segment dut (
    .clk(clk),
    .rst(rst),
    .bus(bus_if)
  );

  always #5 clk = ~clk;

  // Reference: what a single load would show for the given inputs
  function automatic logic [7:0] ref_load(input logic bl, input logic lt, input logic [3:0] v);
    if (bl) return 8'h00;
    if (lt) return {1'b0, 7'h7f};
`ifdef BCD7SEG_HEX_EN
    return {1'b0, tbl[v]};
`else
    if (v > 4'd9) return {1'b1, 7'h00};
    return {1'b0, tbl[v]};
`endif
  endfunction

  // One clock: update the model from the inputs the DUT samples, then settle past the edge
  task automatic tick();
    logic [7:0] r;
    r = ref_load(bus_if.bl, bus_if.lt, bus_if.bcd);
    @(posedge clk);
    if (!rst && bus_if.en) begin
      m_err = r[7];
      m_seg = r[6:0];
    end
    #1;
  endtask

  task automatic drive(input logic en, input logic [3:0] v, input logic bl, input logic lt);
    bus_if.en  = en;
    bus_if.bcd = v;
    bus_if.bl  = bl;
    bus_if.lt  = lt;
  endtask

  task automatic test_reset();
    drive(1'b1, 4'd8, 1'b0, 1'b0);
    tick();
    #2 rst = 1'b1;
    #1;
    m_seg = 7'h00;
    m_err = 1'b0;
    checks++;
    if (bus_if.seg !== 7'b0000000) $display("FAIL reset_seg got %b want 0000000", bus_if.seg);
    else passed++;
    checks++;
    if (bus_if.err !== 1'b0) $display("FAIL reset_err got %b want 0", bus_if.err);
    else passed++;
    @(negedge clk);
    rst = 1'b0;
    tick();
    checks++;
    if (bus_if.seg !== 7'b1111111) $display("FAIL reset_release got %b want 1111111", bus_if.seg);
    else passed++;
  endtask

  task automatic test_sweep();
    for (int d = 0; d < 10; d++) begin
      drive(1'b1, 4'(d), 1'b0, 1'b0);
      tick();
      checks++;
      if (bus_if.seg !== tbl[d] || bus_if.err !== 1'b0)
        $display("FAIL sweep_%0d got seg=%b err=%b want seg=%b err=0", d, bus_if.seg,
                 bus_if.err, tbl[d]);
      else passed++;
    end
  endtask

  task automatic test_invalid();
    drive(1'b1, 4'd10, 1'b0, 1'b0);
    tick();
`ifdef BCD7SEG_HEX_EN
    checks++;
    if (bus_if.seg !== 7'b1110111 || bus_if.err !== 1'b0)
      $display("FAIL hex_a got seg=%b err=%b want seg=1110111 err=0", bus_if.seg, bus_if.err);
    else passed++;
    drive(1'b1, 4'd15, 1'b0, 1'b0);
    tick();
    checks++;
    if (bus_if.seg !== 7'b1110001 || bus_if.err !== 1'b0)
      $display("FAIL hex_f got seg=%b err=%b want seg=1110001 err=0", bus_if.seg, bus_if.err);
    else passed++;
`else
    checks++;
    if (bus_if.seg !== 7'b0000000 || bus_if.err !== 1'b1)
      $display("FAIL invalid_10 got seg=%b err=%b want seg=0000000 err=1", bus_if.seg,
               bus_if.err);
    else passed++;
`endif
    drive(1'b1, 4'd3, 1'b0, 1'b0);
    tick();
    checks++;
    if (bus_if.seg !== 7'b1001111 || bus_if.err !== 1'b0)
      $display("FAIL after_invalid got seg=%b err=%b want seg=1001111 err=0", bus_if.seg,
               bus_if.err);
    else passed++;
  endtask

  task automatic test_priority();
    drive(1'b1, 4'd5, 1'b0, 1'b1);
    tick();
    checks++;
    if (bus_if.seg !== 7'b1111111 || bus_if.err !== 1'b0)
      $display("FAIL prio_lt got seg=%b err=%b want seg=1111111 err=0", bus_if.seg, bus_if.err);
    else passed++;
    drive(1'b1, 4'd5, 1'b1, 1'b1);
    tick();
    checks++;
    if (bus_if.seg !== 7'b0000000 || bus_if.err !== 1'b0)
      $display("FAIL prio_bl got seg=%b err=%b want seg=0000000 err=0", bus_if.seg, bus_if.err);
    else passed++;
    drive(1'b1, 4'd12, 1'b0, 1'b1);
    tick();
    checks++;
    if (bus_if.seg !== 7'b1111111 || bus_if.err !== 1'b0)
      $display("FAIL prio_lt_bad got seg=%b err=%b want seg=1111111 err=0", bus_if.seg,
               bus_if.err);
    else passed++;
    drive(1'b1, 4'd5, 1'b0, 1'b0);
    tick();
    checks++;
    if (bus_if.seg !== 7'b1101101 || bus_if.err !== 1'b0)
      $display("FAIL prio_drop got seg=%b err=%b want seg=1101101 err=0", bus_if.seg,
               bus_if.err);
    else passed++;
  endtask

  task automatic test_hold();
    drive(1'b1, 4'd2, 1'b0, 1'b0);
    tick();
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 4'd7, i[0], i[1]);
      tick();
      checks++;
      if (bus_if.seg !== 7'b1011011 || bus_if.err !== 1'b0)
        $display("FAIL hold_%0d got seg=%b err=%b want seg=1011011 err=0", i, bus_if.seg,
                 bus_if.err);
      else passed++;
    end
    drive(1'b1, 4'd7, 1'b0, 1'b0);
    tick();
    checks++;
    if (bus_if.seg !== 7'b0000111) $display("FAIL hold_release got %b want 0000111", bus_if.seg);
    else passed++;
  endtask

  // Random stream with occasional mid-cycle resets checked against the model every cycle
  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      drive(1'($urandom_range(0, 3) != 0), 4'($urandom_range(0, 15)),
            1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 7) == 0));
      if ($urandom_range(0, 29) == 0) begin
        rst = 1'b1;
        #1;
        m_seg = 7'h00;
        m_err = 1'b0;
        checks++;
        if (bus_if.seg !== 7'h00 || bus_if.err !== 1'b0)
          $display("FAIL rand_rst_%0d got seg=%b err=%b want seg=0000000 err=0", i, bus_if.seg,
                   bus_if.err);
        else passed++;
        tick();
        rst = 1'b0;
      end else begin
        tick();
      end
      checks++;
      if (bus_if.seg !== m_seg || bus_if.err !== m_err)
        $display("FAIL rand_%0d got seg=%b err=%b want seg=%b err=%b", i, bus_if.seg,
                 bus_if.err, m_seg, m_err);
      else passed++;
    end
  endtask

  initial begin
    tbl[0]  = 7'b0111111; tbl[1]  = 7'b0000110; tbl[2]  = 7'b1011011; tbl[3]  = 7'b1001111;
    tbl[4]  = 7'b1100110; tbl[5]  = 7'b1101101; tbl[6]  = 7'b1111101; tbl[7]  = 7'b0000111;
    tbl[8]  = 7'b1111111; tbl[9]  = 7'b1101111; tbl[10] = 7'b1110111; tbl[11] = 7'b1111100;
    tbl[12] = 7'b0111001; tbl[13] = 7'b1011110; tbl[14] = 7'b1111001; tbl[15] = 7'b1110001;
    m_seg = 7'h00;
    m_err = 1'b0;
    rst = 1'b1;
    drive(1'b0, 4'd0, 1'b0, 1'b0);
    #12 rst = 1'b0;
    test_reset();
    test_sweep();
    test_invalid();
    test_priority();
    test_hold();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
